// File: rtl/game_pkg.sv
// Shared types and field widths for the game round controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_ROUND_END = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam int LIVES_W  = 4;
    localparam int DEPTH_W  = 8;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int PIXEL_W  = 16;

endpackage

// File: rtl/game_round_controller_accum.sv
// Per-player collision accumulator: counts colliding pixels inside the goal
// window, latches a sticky hit per round and owns the player's lives.
module collision_accumulator
    import game_pkg::*;
#(
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int COLLISION_THRESHOLD = 64,
    parameter int START_LIVES         = 3
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               init_in,       // game (re)start
    input  logic               playing_in,    // controller is in PLAYING
    input  logic               round_end_in,  // controller is in ROUND_END
    input  logic               new_frame_in,  // last valid pixel of the frame
    input  logic               data_valid_in,
    input  logic               is_person_in,
    input  logic               is_wall_in,
    input  logic [DEPTH_W-1:0] depth_in,      // pre-tick depth
    output logic [LIVES_W-1:0] lives_out,
    output logic               alive_out,
    output logic               survives_out   // alive after this round's penalty
);

    localparam int CNT_W  = $clog2(COLLISION_THRESHOLD + 1);
    localparam int WIN_LO = (GOAL_DEPTH > GOAL_DEPTH_DELTA) ? GOAL_DEPTH - GOAL_DEPTH_DELTA : 0;
    localparam int WIN_HI = GOAL_DEPTH + GOAL_DEPTH_DELTA;
    localparam logic [CNT_W-1:0]   CNT_THR   = CNT_W'(COLLISION_THRESHOLD);
    localparam logic [LIVES_W-1:0] LIVES_INI = LIVES_W'(START_LIVES);

    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_sum;
    logic               hit_reg, hit_next;
    logic [LIVES_W-1:0] lives_reg, lives_next, lives_dec;
    logic               alive_reg, alive_next;
    logic               in_window, pixel_hit;

    assign in_window = (int'(depth_in) >= WIN_LO) && (int'(depth_in) <= WIN_HI);
    assign pixel_hit = playing_in & in_window & data_valid_in & is_person_in & is_wall_in & alive_reg;
    // Current pixel folded in so the frame's last pixel counts toward the verdict.
    assign cnt_sum   = (pixel_hit && (cnt_reg != CNT_THR)) ? cnt_reg + CNT_W'(1) : cnt_reg;
    assign lives_dec = (hit_reg && (lives_reg != '0)) ? lives_reg - LIVES_W'(1) : lives_reg;
    assign survives_out = (lives_dec != '0);
    assign lives_out    = lives_reg;
    assign alive_out    = alive_reg;

    // Next-state for counter, hit flag and lives.
    always_comb begin
        cnt_next   = cnt_reg;
        hit_next   = hit_reg;
        lives_next = lives_reg;
        alive_next = alive_reg;
        if (init_in) begin
            cnt_next   = '0;
            hit_next   = 1'b0;
            lives_next = LIVES_INI;
            alive_next = 1'b1;
        end else if (round_end_in) begin
            cnt_next   = '0;
            hit_next   = 1'b0;
            lives_next = lives_dec;
            alive_next = survives_out;
        end else if (playing_in) begin
            if (new_frame_in) begin
                if (cnt_sum >= CNT_THR) begin
                    hit_next = 1'b1;
                end
                cnt_next = '0;
            end else begin
                cnt_next = cnt_sum;
            end
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_reg   <= '0;
            hit_reg   <= 1'b0;
            lives_reg <= '0;
            alive_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            hit_reg   <= hit_next;
            lives_reg <= lives_next;
            alive_reg <= alive_next;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Multi-player round controller: pixel pass-through with collision flags,
// wall depth schedule, round/wall sequencing and lives tracking.
module game_round_controller
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int NUM_PLAYERS         = 2,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int MAX_WALL_DEPTH      = 75,
    parameter int MAX_FRAMES_PER_TICK = 15,
    parameter int MIN_FRAMES_PER_TICK = 2,
    parameter int COLLISION_THRESHOLD = 64,
    parameter int NUM_WALLS           = 8,
    parameter int START_LIVES         = 3,
    localparam int WIDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           start_in,
    input  logic [HCOUNT_W-1:0]            hcount_in,
    input  logic [VCOUNT_W-1:0]            vcount_in,
    input  logic [PIXEL_W-1:0]             pixel_in,
    input  logic                           data_valid_in,
    input  logic [NUM_PLAYERS-1:0]         is_person_in,
    input  logic                           is_wall_in,
    output logic [HCOUNT_W-1:0]            hcount_out,
    output logic [VCOUNT_W-1:0]            vcount_out,
    output logic [PIXEL_W-1:0]             pixel_out,
    output logic                           data_valid_out,
    output logic                           is_wall_out,
    output logic [NUM_PLAYERS-1:0]         is_person_out,
    output logic [NUM_PLAYERS-1:0]         is_collision_out,
    output logic [DEPTH_W-1:0]             wall_depth_out,
    output logic [WIDX_W-1:0]              wall_idx_out,
    output logic                           wall_load_out,
    output logic [7:0]                     round_out,
    output logic [LIVES_W*NUM_PLAYERS-1:0] lives_out,
    output logic [NUM_PLAYERS-1:0]         player_alive_out,
    output logic [1:0]                     game_state_out
);

    localparam int FPT_W = $clog2(MAX_FRAMES_PER_TICK + 1);
    localparam logic [FPT_W-1:0]    FPT_MAX    = FPT_W'(MAX_FRAMES_PER_TICK);
    localparam logic [FPT_W-1:0]    FPT_MIN    = FPT_W'(MIN_FRAMES_PER_TICK);
    localparam logic [DEPTH_W-1:0]  DEPTH_LAST = DEPTH_W'(MAX_WALL_DEPTH - 1);
    localparam logic [WIDX_W-1:0]   WIDX_LAST  = WIDX_W'(NUM_WALLS - 1);
    localparam logic [HCOUNT_W-1:0] H_LAST     = HCOUNT_W'(SCREEN_WIDTH - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST     = VCOUNT_W'(SCREEN_HEIGHT - 1);

    game_state_t          state_reg, state_next;
    logic [DEPTH_W-1:0]   depth_reg, depth_next;
    logic [FPT_W-1:0]     fpt_reg, fpt_next;
    logic [FPT_W-1:0]     frame_cnt_reg, frame_cnt_next;
    logic [7:0]           round_reg, round_next;
    logic [WIDX_W-1:0]    wall_idx_reg, wall_idx_next;
    logic                 wall_load_reg, wall_load_next;
    logic [NUM_PLAYERS-1:0] survives;
    logic                 new_frame, start_game;

    assign new_frame  = data_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    assign start_game = start_in && ((state_reg == ST_IDLE) || (state_reg == ST_GAME_OVER));

    // Pixel pipeline: one register stage, collisions deliberately ungated.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_out       <= '0;
            vcount_out       <= '0;
            pixel_out        <= '0;
            data_valid_out   <= 1'b0;
            is_wall_out      <= 1'b0;
            is_person_out    <= '0;
            is_collision_out <= '0;
        end else begin
            hcount_out       <= hcount_in;
            vcount_out       <= vcount_in;
            pixel_out        <= pixel_in;
            data_valid_out   <= data_valid_in;
            is_wall_out      <= is_wall_in;
            is_person_out    <= is_person_in;
            is_collision_out <= is_person_in & {NUM_PLAYERS{is_wall_in}};
        end
    end

    // Game FSM next-state plus depth/round/wall schedule.
    always_comb begin
        state_next     = state_reg;
        depth_next     = depth_reg;
        frame_cnt_next = frame_cnt_reg;
        fpt_next       = fpt_reg;
        round_next     = round_reg;
        wall_idx_next  = wall_idx_reg;
        wall_load_next = 1'b0;
        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_in) begin
                    state_next     = ST_PLAYING;
                    depth_next     = '0;
                    frame_cnt_next = '0;
                    fpt_next       = FPT_MAX;
                    round_next     = '0;
                    wall_idx_next  = '0;
                    wall_load_next = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (new_frame) begin
                    if (frame_cnt_reg == fpt_reg - FPT_W'(1)) begin
                        frame_cnt_next = '0;
                        if (depth_reg >= DEPTH_LAST) begin
                            state_next = ST_ROUND_END;
                        end else begin
                            depth_next = depth_reg + DEPTH_W'(1);
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FPT_W'(1);
                    end
                end
            end
            ST_ROUND_END: begin
                if (survives == '0) begin
                    state_next = ST_GAME_OVER;
                end else begin
                    state_next     = ST_PLAYING;
                    round_next     = (round_reg == 8'hFF) ? round_reg : round_reg + 8'd1;
                    wall_idx_next  = (wall_idx_reg == WIDX_LAST) ? '0 : wall_idx_reg + WIDX_W'(1);
                    fpt_next       = (fpt_reg > FPT_MIN) ? fpt_reg - FPT_W'(1) : FPT_MIN;
                    depth_next     = '0;
                    frame_cnt_next = '0;
                    wall_load_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Game FSM and schedule registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            depth_reg     <= '0;
            frame_cnt_reg <= '0;
            fpt_reg       <= FPT_MAX;
            round_reg     <= '0;
            wall_idx_reg  <= '0;
            wall_load_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            depth_reg     <= depth_next;
            frame_cnt_reg <= frame_cnt_next;
            fpt_reg       <= fpt_next;
            round_reg     <= round_next;
            wall_idx_reg  <= wall_idx_next;
            wall_load_reg <= wall_load_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            collision_accumulator #(
                .GOAL_DEPTH          (GOAL_DEPTH),
                .GOAL_DEPTH_DELTA    (GOAL_DEPTH_DELTA),
                .COLLISION_THRESHOLD (COLLISION_THRESHOLD),
                .START_LIVES         (START_LIVES)
            ) u_accum (
                .clk_in        (clk_in),
                .rst_n_in      (rst_n_in),
                .init_in       (start_game),
                .playing_in    (state_reg == ST_PLAYING),
                .round_end_in  (state_reg == ST_ROUND_END),
                .new_frame_in  (new_frame),
                .data_valid_in (data_valid_in),
                .is_person_in  (is_person_in[gi]),
                .is_wall_in    (is_wall_in),
                .depth_in      (depth_reg),
                .lives_out     (lives_out[LIVES_W*gi +: LIVES_W]),
                .alive_out     (player_alive_out[gi]),
                .survives_out  (survives[gi])
            );
        end
    endgenerate

    assign wall_depth_out = depth_reg;
    assign wall_idx_out   = wall_idx_reg;
    assign wall_load_out  = wall_load_reg;
    assign round_out      = round_reg;
    assign game_state_out = state_reg;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller on a tiny 8x4 screen.
module tb_game_round_controller;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        data_valid_in;
    logic [1:0]  is_person_in;
    logic        is_wall_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [15:0] pixel_out;
    logic        data_valid_out;
    logic        is_wall_out;
    logic [1:0]  is_person_out;
    logic [1:0]  is_collision_out;
    logic [7:0]  wall_depth_out;
    logic [1:0]  wall_idx_out;
    logic        wall_load_out;
    logic [7:0]  round_out;
    logic [7:0]  lives_out;
    logic [1:0]  player_alive_out;
    logic [1:0]  game_state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    game_round_controller #(
        .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .NUM_PLAYERS(2),
        .GOAL_DEPTH(3), .GOAL_DEPTH_DELTA(1), .MAX_WALL_DEPTH(6),
        .MAX_FRAMES_PER_TICK(3), .MIN_FRAMES_PER_TICK(1),
        .COLLISION_THRESHOLD(2), .NUM_WALLS(4), .START_LIVES(3)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .data_valid_in(data_valid_in), .is_person_in(is_person_in), .is_wall_in(is_wall_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .pixel_out(pixel_out),
        .data_valid_out(data_valid_out), .is_wall_out(is_wall_out),
        .is_person_out(is_person_out), .is_collision_out(is_collision_out),
        .wall_depth_out(wall_depth_out), .wall_idx_out(wall_idx_out),
        .wall_load_out(wall_load_out), .round_out(round_out), .lives_out(lives_out),
        .player_alive_out(player_alive_out), .game_state_out(game_state_out)
    );

    // One full 8x4 frame; the first n0/n1 pixels carry player 0/1, wall everywhere.
    task automatic drive_frame(input int n0, input int n1);
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 8; h++) begin
                @(negedge clk_in);
                hcount_in     = 11'(h);
                vcount_in     = 10'(v);
                pixel_in      = 16'(v * 8 + h);
                data_valid_in = 1'b1;
                is_wall_in    = 1'b1;
                is_person_in  = {((v * 8 + h) < n1), ((v * 8 + h) < n0)};
            end
        end
        @(negedge clk_in);
        data_valid_in = 1'b0;
        is_person_in  = 2'b00;
        is_wall_in    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        checks++;
        if ({game_state_out, wall_depth_out, round_out, lives_out, player_alive_out,
             wall_idx_out, wall_load_out} !== 31'd0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d depth=%0d round=%0d lives=%h alive=%b widx=%0d load=%b, required all 0",
                     game_state_out, wall_depth_out, round_out, lives_out, player_alive_out,
                     wall_idx_out, wall_load_out);
        end
        checks++;
        if ({data_valid_out, hcount_out, pixel_out, is_collision_out} !== 30'd0) begin
            errors++;
            $display("FAIL reset_pipe: dv=%b h=%0d pix=%h coll=%b, required all 0",
                     data_valid_out, hcount_out, pixel_out, is_collision_out);
        end
        rst_n_in = 1'b1;
        $display("reset: state=%0d lives=%h", game_state_out, lives_out);
    endtask

    task automatic test_pipeline();
        logic [10:0] hv[3]  = '{11'd3, 11'd6, 11'd0};
        logic [9:0]  vv[3]  = '{10'd1, 10'd2, 10'd3};
        logic [15:0] pv[3]  = '{16'hABCD, 16'h1234, 16'hF00F};
        logic [1:0]  per[3] = '{2'b01, 2'b11, 2'b10};
        logic        wal[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  col[3] = '{2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            hcount_in = hv[i]; vcount_in = vv[i]; pixel_in = pv[i];
            data_valid_in = 1'b1; is_person_in = per[i]; is_wall_in = wal[i];
            @(negedge clk_in);
            data_valid_in = 1'b0;
            checks++;
            if ({hcount_out, vcount_out, pixel_out, data_valid_out, is_person_out, is_wall_out} !==
                {hv[i], vv[i], pv[i], 1'b1, per[i], wal[i]}) begin
                errors++;
                $display("FAIL pipe_fields[%0d]: h=%0d v=%0d pix=%h dv=%b per=%b wall=%b, required h=%0d v=%0d pix=%h dv=1 per=%b wall=%b",
                         i, hcount_out, vcount_out, pixel_out, data_valid_out, is_person_out, is_wall_out,
                         hv[i], vv[i], pv[i], per[i], wal[i]);
            end
            checks++;
            if (is_collision_out !== col[i]) begin
                errors++;
                $display("FAIL pipe_collision[%0d]: got %b, required %b", i, is_collision_out, col[i]);
            end
            $display("pipeline[%0d]: h=%0d v=%0d pix=%h coll=%b", i, hcount_out, vcount_out, pixel_out, is_collision_out);
        end
        is_person_in = 2'b00;
        is_wall_in   = 1'b0;
    endtask

    task automatic test_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        checks++;
        if ({game_state_out, wall_load_out, lives_out, player_alive_out, round_out, wall_idx_out, wall_depth_out} !==
            {2'd1, 1'b1, 8'h33, 2'b11, 8'd0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL start: state=%0d load=%b lives=%h alive=%b round=%0d widx=%0d depth=%0d, required 1 1 33 11 0 0 0",
                     game_state_out, wall_load_out, lives_out, player_alive_out, round_out, wall_idx_out, wall_depth_out);
        end
        @(negedge clk_in);
        checks++;
        if (wall_load_out !== 1'b0) begin
            errors++;
            $display("FAIL start_load_pulse: load=%b, required 0", wall_load_out);
        end
        $display("start: state=%0d lives=%h round=%0d", game_state_out, lives_out, round_out);
    endtask

    task automatic test_ignore_start(input logic [7:0] exp_round);
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        checks++;
        if ({game_state_out, wall_load_out, round_out} !== {2'd1, 1'b0, exp_round}) begin
            errors++;
            $display("FAIL ignore_start: state=%0d load=%b round=%0d, required 1 0 %0d",
                     game_state_out, wall_load_out, round_out, exp_round);
        end
        $display("ignore_start: state=%0d round=%0d", game_state_out, round_out);
    endtask

    // Plays one round, checking depth after every frame and the ROUND_END outcome.
    task automatic run_round(input string name, input int fpt,
                             input int p0_cnt, input logic [7:0] p0_mask,
                             input int p1_cnt, input logic [7:0] p1_mask,
                             input logic [1:0] exp_state, input logic [7:0] exp_lives,
                             input logic [1:0] exp_alive, input logic [7:0] exp_round,
                             input logic [1:0] exp_widx);
        int k = 0;
        int d;
        int exp_frames = 6 * fpt;
        logic [7:0] exp_depth;
        while (k < exp_frames) begin
            d = int'(wall_depth_out);
            drive_frame((d < 8 && p0_mask[d]) ? p0_cnt : 0, (d < 8 && p1_mask[d]) ? p1_cnt : 0);
            k++;
            if (k < exp_frames) begin
                checks++;
                if ({game_state_out, wall_depth_out} !== {2'd1, 8'(k / fpt)}) begin
                    errors++;
                    $display("FAIL %s depth_frame%0d: state=%0d depth=%0d, required 1 %0d",
                             name, k, game_state_out, wall_depth_out, k / fpt);
                end
            end else begin
                checks++;
                if ({game_state_out, wall_depth_out} !== {2'd2, 8'd5}) begin
                    errors++;
                    $display("FAIL %s round_end: state=%0d depth=%0d, required 2 5",
                             name, game_state_out, wall_depth_out);
                end
            end
        end
        @(negedge clk_in);
        exp_depth = (exp_state == 2'd1) ? 8'd0 : 8'd5;
        checks++;
        if ({game_state_out, lives_out, player_alive_out, round_out, wall_idx_out, wall_depth_out} !==
            {exp_state, exp_lives, exp_alive, exp_round, exp_widx, exp_depth}) begin
            errors++;
            $display("FAIL %s after: state=%0d lives=%h alive=%b round=%0d widx=%0d depth=%0d, required %0d %h %b %0d %0d %0d",
                     name, game_state_out, lives_out, player_alive_out, round_out, wall_idx_out, wall_depth_out,
                     exp_state, exp_lives, exp_alive, exp_round, exp_widx, exp_depth);
        end
        checks++;
        if (wall_load_out !== (exp_state == 2'd1)) begin
            errors++;
            $display("FAIL %s load: got %b, required %b", name, wall_load_out, exp_state == 2'd1);
        end
        @(negedge clk_in);
        checks++;
        if ({wall_load_out, game_state_out} !== {1'b0, exp_state}) begin
            errors++;
            $display("FAIL %s load_pulse: load=%b state=%0d, required 0 %0d",
                     name, wall_load_out, game_state_out, exp_state);
        end
        $display("%s: frames=%0d state=%0d lives=%h alive=%b round=%0d widx=%0d",
                 name, k, game_state_out, lives_out, player_alive_out, round_out, wall_idx_out);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            hcount_in = 11'(i % 8); vcount_in = 10'(i / 8); pixel_in = 16'hBEEF;
            data_valid_in = 1'b1; is_person_in = 2'b11; is_wall_in = 1'b1;
        end
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({game_state_out, wall_depth_out, round_out, lives_out, player_alive_out, wall_idx_out} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset_ctrl: state=%0d depth=%0d round=%0d lives=%h alive=%b widx=%0d, required all 0",
                     game_state_out, wall_depth_out, round_out, lives_out, player_alive_out, wall_idx_out);
        end
        checks++;
        if ({data_valid_out, pixel_out, is_collision_out, is_person_out} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset_pipe: dv=%b pix=%h coll=%b per=%b, required all 0",
                     data_valid_out, pixel_out, is_collision_out, is_person_out);
        end
        @(negedge clk_in);
        data_valid_in = 1'b0; is_person_in = 2'b00; is_wall_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({game_state_out, data_valid_out, wall_depth_out} !== {2'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset_release: state=%0d dv=%b depth=%0d, required 0 0 0",
                     game_state_out, data_valid_out, wall_depth_out);
        end
        $display("async_reset: state=%0d dv=%b", game_state_out, data_valid_out);
    endtask

    task automatic test_game_over_hold();
        drive_frame(4, 4);
        checks++;
        if ({game_state_out, wall_depth_out, round_out, wall_idx_out, lives_out} !==
            {2'd3, 8'd5, 8'd2, 2'd2, 8'h00}) begin
            errors++;
            $display("FAIL game_over_hold: state=%0d depth=%0d round=%0d widx=%0d lives=%h, required 3 5 2 2 00",
                     game_state_out, wall_depth_out, round_out, wall_idx_out, lives_out);
        end
        $display("game_over_hold: state=%0d depth=%0d", game_state_out, wall_depth_out);
    endtask

    initial begin
        rst_n_in = 1'b1;
        start_in = 1'b0;
        hcount_in = '0; vcount_in = '0; pixel_in = '0;
        data_valid_in = 1'b0; is_person_in = 2'b00; is_wall_in = 1'b0;
        #1 rst_n_in = 1'b0;

        test_reset();
        test_pipeline();

        // Game A: schedule, threshold and window tests.
        test_start();
        run_round("sched_r0",   3, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd1, 2'd1);
        test_ignore_start(8'd1);
        run_round("below_thr",  2, 1, 8'h08, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd2, 2'd2);
        run_round("at_thr",     1, 2, 8'h08, 0, 8'h00, 2'd1, 8'h32, 2'b11, 8'd3, 2'd3);
        run_round("out_window", 1, 4, 8'h23, 0, 8'h00, 2'd1, 8'h32, 2'b11, 8'd4, 2'd0);
        test_async_reset();

        // Game B: both players hit every round until game over, then restart.
        test_start();
        run_round("hit_r0", 3, 2, 8'h08, 2, 8'h08, 2'd1, 8'h22, 2'b11, 8'd1, 2'd1);
        run_round("hit_r1", 2, 2, 8'h08, 2, 8'h08, 2'd1, 8'h11, 2'b11, 8'd2, 2'd2);
        run_round("hit_r2", 1, 2, 8'h08, 2, 8'h08, 2'd3, 8'h00, 2'b00, 8'd2, 2'd2);
        test_game_over_hold();
        test_start();

        // Game C: clean rounds show the speed floor and wall index wrap.
        run_round("clean_r0", 3, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd1, 2'd1);
        run_round("clean_r1", 2, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd2, 2'd2);
        run_round("clean_r2", 1, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd3, 2'd3);
        run_round("clean_r3", 1, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd4, 2'd0);
        run_round("clean_r4", 1, 0, 8'h00, 0, 8'h00, 2'd1, 8'h33, 2'b11, 8'd5, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Multi-player, multi-round successor to the single-wall game logic stage. It sits in the pixel pipeline between person segmentation and the wall/overlay renderer. It advances the wall depth on a per-round speed schedule and counts per-player collision pixels inside the goal window against a threshold. It also tracks lives, sequences rounds and wall selection, and reports game state. The wall mask bit arrives pixel-aligned from external mask storage, which is reloaded via a request pulse.

Parameters:
SCREEN_WIDTH, 1280, active pixels per line
SCREEN_HEIGHT, 720, active lines per frame
NUM_PLAYERS, 2, independent person channels (1..4)
GOAL_DEPTH, 60, centre of scoring window
GOAL_DEPTH_DELTA, 10, half-width of scoring window (inclusive)
MAX_WALL_DEPTH, 75, depth at which round ends (≤255)
MAX_FRAMES_PER_TICK, 15, frames per depth step in round 0
MIN_FRAMES_PER_TICK, 2, speed floor (≥1)
COLLISION_THRESHOLD, 64, colliding pixels in one frame that count as a hit (≥1)
NUM_WALLS, 8, wall masks available; index wraps
START_LIVES, 3, lives per player at game start (≤15)

Ports:
clk_in  in  1  pixel clock
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  single-cycle start/restart request
hcount_in  in  11  pixel column
vcount_in  in  10  pixel row
pixel_in  in  16  RGB565 pixel
data_valid_in  in  1  pixel qualifier
is_person_in  in  NUM_PLAYERS  per-player mask bit for this pixel
is_wall_in  in  1  wall mask bit for this pixel
hcount_out / vcount_out / pixel_out / data_valid_out  out  11/10/16/1  pipeline pass-through
is_wall_out  out  1  registered is_wall_in
is_person_out  out  NUM_PLAYERS  registered is_person_in
is_collision_out  out  NUM_PLAYERS  registered is_person_in[p] & is_wall_in
wall_depth_out  out  8  current wall depth
wall_idx_out  out  clog2(NUM_WALLS)  selected wall mask
wall_load_out  out  1  one-cycle pulse: load mask wall_idx_out
round_out  out  8  round number, saturates at 255
lives_out  out  4*NUM_PLAYERS  lives; player p at bits [4p+3:4p]
player_alive_out  out  NUM_PLAYERS  lives nonzero
game_state_out  out  2  IDLE=0, PLAYING=1, ROUND_END=2, GAME_OVER=3

Behaviour:
- Reset, asynchronous and immediate, including mid-frame: all outputs 0, state IDLE, frames_per_tick=MAX_FRAMES_PER_TICK, all internal counters 0.
- Pixel pipeline:
  - Fixed 1-cycle latency in every state.
  - Collision outputs are not gated by state or alive status.
- new_frame = data_valid_in & hcount_in==SCREEN_WIDTH-1 & vcount_in==SCREEN_HEIGHT-1.
- IDLE:
  - Depth held at 0.
  - On start_in: lives=START_LIVES, alive all 1, round=0, wall_idx=0, frames_per_tick=MAX, wall_load_out pulses next cycle; go to PLAYING.
- PLAYING, frame counter:
  - Increments on each new_frame.
  - At new_frame with count==frames_per_tick-1: count clears and a tick fires.
  - On a tick with depth<MAX_WALL_DEPTH-1: depth+1.
  - On a tick with depth==MAX_WALL_DEPTH-1: go to ROUND_END; depth holds.
- PLAYING, collision counting:
  - Per-player counter (width clog2(THRESHOLD+1), saturating at THRESHOLD) increments on data_valid_in & is_person_in[p] & is_wall_in & alive[p].
  - Counting happens only while GOAL_DEPTH-GOAL_DEPTH_DELTA ≤ depth ≤ GOAL_DEPTH+GOAL_DEPTH_DELTA.
  - At new_frame: the new_frame pixel's own contribution is included; counter ≥THRESHOLD sets sticky hit[p]; counters clear.
  - The window test uses the pre-tick depth when a tick coincides.
- start_in is ignored in PLAYING and ROUND_END.
- ROUND_END (exactly 1 cycle):
  - For each player with hit: lives-1, saturating at 0.
  - alive = lives≠0, evaluated on post-decrement values.
  - If no player alive: go to GAME_OVER.
  - Otherwise: round+1 (saturate), wall_idx=(wall_idx+1) mod NUM_WALLS, frames_per_tick=max(fpt-1, MIN), depth=0, frame counter=0, hit cleared, wall_load_out pulse; go to PLAYING.
- GAME_OVER:
  - All values hold.
  - start_in behaves as in IDLE.
- wall_load_out is high for exactly 1 cycle per load.

Decomposition:
- Package game_pkg holds:
  - game_state_t enum (2-bit, encodings above)
  - LIVES_W=4
  - DEPTH_W=8
  - pixel pipeline field widths
- Sub-module collision_accumulator, instantiated per player, owns:
  - saturating pixel counter
  - window gating
  - sticky hit flag
  - lives register

Test Plan:
Bench parameters for all scenarios: W=8, H=4, NUM_PLAYERS=2, GOAL=3, DELTA=1, MAX_WALL_DEPTH=6, MAX_FPT=3, MIN_FPT=1, THRESHOLD=2, NUM_WALLS=4, START_LIVES=3.
1. Start, no persons -> depth steps every 3 frames to 5. Next tick gives ROUND_END for 1 cycle, then round_out=1, wall_idx=1, one wall_load pulse, and subsequent ticks every 2 frames.
2. Player0 has 1 colliding pixel/frame at depth 3 -> lives stay 3. With 2 pixels/frame -> lives0=2 after ROUND_END; lives1 stays 3.
3. Player0 has 4 colliding pixels/frame at depths 0,1,5 only -> no life lost.
4. Both players hit in 3 consecutive rounds -> GAME_OVER (state 3), alive=00. start_in then restores lives 3/3, round 0, wall_idx 0, state PLAYING.
5. 5 clean rounds -> frames_per_tick floors at 1; wall_idx sequence 1,2,3,0,1.
6. rst_n_in low mid-frame in PLAYING, asynchronous to clk -> all outputs 0 before the next edge. After release, state IDLE and data_valid_out=0.
